xconverter_wb_downsize: RTL and testbench

Read-side width converter between the weight-buffer SRAM and the DMA master. It fetches wide SRAM lines, either 416-bit with 13 words or 256-bit with 8 words, and unpacks them into a continuous stream of 128-bit beats toward the DMA. Output uses a valid/ready handshake. It is the counterpart of the 128→416/256 write-side packer, and the word ordering matches it exactly, so a write-then-read round trip is lossless.

---
 rtl/xconverter_wb_downsize_pkg.sv | 29 ++
 rtl/xconverter_wb_downsize_if.sv | 25 ++
 rtl/xconverter_wb_downsize_word_buf.sv | 59 +++++
 rtl/xconverter_wb_downsize.sv | 92 +++++++++
 tb/tb_xconverter_wb_downsize.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/xconverter_wb_downsize_pkg.sv
// Shared constants and types for the weight-buffer width converters.
// The write-side packer uses the same line layout and word ordering.
package xconv_wb_pkg;
    localparam int DWS        = 128;
    localparam int DWD        = 416;
    localparam int WORD_W     = 32;
    localparam int W416       = 13;
    localparam int W256       = 8;
    localparam int BEAT_WORDS = 4;
    localparam int BUF_WORDS  = 16;
    localparam int OFS256     = 160;
    localparam int CNT_W      = $clog2(BUF_WORDS + 1);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_416 = 2'd1,
        MODE_256 = 2'd2
    } mode_e;

    function automatic logic [CNT_W-1:0] line_words(input mode_e m);
        case (m)
            MODE_416: return CNT_W'(W416);
            MODE_256: return CNT_W'(W256);
            default:  return '0;
        endcase
    endfunction
endpackage

// File: rtl/xconverter_wb_downsize_if.sv
// SRAM read port and DMA beat stream of the read-side width converter.
interface xconverter_wb_downsize_if #(
    parameter int DWS   = 128,
    parameter int DWD   = 416,
    parameter int AW_WB = 13
) ();
    logic             wb_read;
    logic [AW_WB-1:0] wb_raddr;
    logic [DWD-1:0]   wb_rdata;
    // Beat moves on a cycle with mvalid & mready; while mvalid is high and
    // mready low, mvalid and rdata stay unchanged until the beat is taken.
    logic             mvalid;
    logic             mready;
    logic [DWS-1:0]   rdata;

    modport master (
        output wb_read, wb_raddr, mvalid, rdata,
        input  wb_rdata, mready
    );

    modport slave (
        input  wb_read, wb_raddr, mvalid, rdata,
        output wb_rdata, mready
    );
endinterface

// File: rtl/xconverter_wb_downsize_word_buf.sv
// 16-word staging FIFO: appends one SRAM line (8 or 13 words) and pops
// 4-word beats, both possibly in the same cycle; word 0 is the oldest.
module xconv_word_buf
    import xconv_wb_pkg::*;
(
    input  logic             xclk,
    input  logic             xreset_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             pop_i,
    input  mode_e            mode_i,
    input  logic [DWD-1:0]   line_i,
    output logic [DWS-1:0]   head_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o
);
    logic [BUF_WORDS-1:0][WORD_W-1:0] buf_q, buf_d, buf_s;
    logic [CNT_W-1:0]                 cnt_q, cnt_d, cnt_pop, n_load;
    word_t                            line_w [BUF_WORDS];
    logic [3:0]                       idx;

    always_comb begin
        for (int j = 0; j < BUF_WORDS; j++) line_w[j] = '0;
        if (mode_i == MODE_256) begin
            for (int j = 0; j < W256; j++) line_w[j] = line_i[OFS256 + WORD_W*j +: WORD_W];
        end else begin
            for (int j = 0; j < W416; j++) line_w[j] = line_i[WORD_W*j +: WORD_W];
        end
    end

    // Pop shifts first, then the returning line lands right after the survivors.
    always_comb begin
        cnt_pop = pop_i ? cnt_q - CNT_W'(BEAT_WORDS) : cnt_q;
        n_load  = load_i ? line_words(mode_i) : '0;
        buf_s   = pop_i ? (buf_q >> (BEAT_WORDS*WORD_W)) : buf_q;
        buf_d   = buf_s;
        idx     = '0;
        for (int i = 0; i < BUF_WORDS; i++) begin
            idx = 4'(CNT_W'(i) - cnt_pop);
            if (load_i && (CNT_W'(i) >= cnt_pop) && (CNT_W'(i) < cnt_pop + n_load))
                buf_d[i] = line_w[idx];
        end
        cnt_d = flush_i ? '0 : cnt_pop + n_load;
    end

    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = buf_q[BEAT_WORDS-1:0];
    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
endmodule

// File: rtl/xconverter_wb_downsize.sv
// Read-side converter: fetches 416/256-bit weight-buffer lines and streams
// them to the DMA as 128-bit beats; one SRAM read outstanding at a time.
module xconverter_wb_downsize
    import xconv_wb_pkg::*;
#(
    parameter int DWS   = 128,
    parameter int DWD   = 416,
    parameter int AW_WB = 13
) (
    input  logic                     xclk,
    input  logic                     xreset_n,
    input  logic [31:0]              maddr_sram_start,
    input  logic                     mode_wb2m416,
    input  logic                     mode_wb2m256,
    xconverter_wb_downsize_if.master bus,
    output logic [CNT_W-1:0]         dbg_cnt_o,
    output mode_e                    dbg_mode_o
);
    mode_e            mode_cur, mode_q;
    logic             active, start, flush, pop, load, issue, mvalid;
    logic             wb_read_q, rd_pend_q;
    logic [AW_WB-1:0] raddr_q;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W:0]   need;
    logic [DWS-1:0]   head;
    logic [DWD-1:0]   line_in;
    logic             unused_addr_hi;

    always_comb begin
        mode_cur = MODE_OFF;
        if (mode_wb2m256)      mode_cur = MODE_256;
        else if (mode_wb2m416) mode_cur = MODE_416;
    end

    // A new or switched mode is a fresh job: flush and restart at the new address.
    assign active = (mode_cur != MODE_OFF);
    assign start  = active && (mode_cur != mode_q);
    assign flush  = start || !active;
    assign mvalid = (cnt >= CNT_W'(BEAT_WORDS));
    assign pop    = mvalid && bus.mready;
    assign load   = rd_pend_q;

    // Space is judged on the post-update count, so a read can issue in the
    // very cycle the previous line is landing.
    assign need  = {1'b0, cnt_nxt} + {1'b0, line_words(mode_cur)};
    assign issue = active && !start && !wb_read_q && (need <= (CNT_W+1)'(BUF_WORDS));

    assign line_in = bus.wb_rdata;

    xconv_word_buf u_buf (
        .xclk     (xclk),
        .xreset_n (xreset_n),
        .flush_i  (flush),
        .load_i   (load),
        .pop_i    (pop),
        .mode_i   (mode_cur),
        .line_i   (line_in),
        .head_o   (head),
        .cnt_o    (cnt),
        .cnt_d_o  (cnt_nxt)
    );

    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) begin
            mode_q    <= MODE_OFF;
            wb_read_q <= 1'b0;
            rd_pend_q <= 1'b0;
            raddr_q   <= '0;
        end else begin
            mode_q    <= mode_cur;
            rd_pend_q <= wb_read_q && active && !start;
            if (!active) begin
                wb_read_q <= 1'b0;
                raddr_q   <= maddr_sram_start[AW_WB-1:0];
            end else if (start) begin
                wb_read_q <= 1'b1;
                raddr_q   <= maddr_sram_start[AW_WB-1:0];
            end else begin
                wb_read_q <= issue;
                if (wb_read_q) raddr_q <= raddr_q + AW_WB'(1);
            end
        end
    end

    assign bus.wb_read  = wb_read_q;
    assign bus.wb_raddr = raddr_q;
    assign bus.mvalid   = mvalid;
    assign bus.rdata    = head;
    assign dbg_cnt_o    = cnt;
    assign dbg_mode_o   = mode_q;
    assign unused_addr_hi = ^maddr_sram_start[31:AW_WB];
endmodule

// File: tb/tb_xconverter_wb_downsize.sv
// Self-checking bench for xconverter_wb_downsize: SRAM line model, beat
// scoreboard fed per job, and timing/boundary checks.
module tb_xconverter_wb_downsize;
    import xconv_wb_pkg::*;

    logic             xclk = 1'b0;
    logic             xreset_n;
    logic [31:0]      maddr_sram_start;
    logic             mode_wb2m416;
    logic             mode_wb2m256;
    logic [CNT_W-1:0] dbg_cnt;
    mode_e            dbg_mode;

    xconverter_wb_downsize_if #(.DWS(128), .DWD(416), .AW_WB(13)) bus ();

    xconverter_wb_downsize #(.DWS(128), .DWD(416), .AW_WB(13)) dut (
        .xclk             (xclk),
        .xreset_n         (xreset_n),
        .maddr_sram_start (maddr_sram_start),
        .mode_wb2m416     (mode_wb2m416),
        .mode_wb2m256     (mode_wb2m256),
        .bus              (bus),
        .dbg_cnt_o        (dbg_cnt),
        .dbg_mode_o       (dbg_mode)
    );

    // clock / reset
    always #5 xclk = ~xclk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  exp_q[$];
    logic [12:0]  exp_addr;
    int           beats;
    bit           mon_en = 1'b0;
    logic         prev_valid, prev_ready;
    logic [127:0] prev_rdata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [12:0] a, input int j);
        return {3'b000, a, 8'h5A, 4'h0, 4'(j)};
    endfunction

    function automatic logic [415:0] mk_line(input logic [12:0] a, input logic m256);
        logic [415:0] l;
        l = '0;
        if (m256) begin
            for (int k = 0; k < 5; k++) l[32*k +: 32] = 32'hDEAD_BEEF;
            for (int j = 0; j < 8; j++) l[160 + 32*j +: 32] = word_of(a, j);
        end else begin
            for (int j = 0; j < 13; j++) l[32*j +: 32] = word_of(a, j);
        end
        return l;
    endfunction

    // SRAM model: line data valid the cycle after wb_read, garbage otherwise
    always @(posedge xclk) begin
        if (bus.wb_read) bus.wb_rdata <= mk_line(bus.wb_raddr, mode_wb2m256);
        else             bus.wb_rdata <= {13{$urandom}};
    end

    // scoreboard / monitor
    always @(negedge xclk) begin
        logic [127:0] exp_beat;
        if (mon_en) begin
            chk("cnt_le_16", 128'(dbg_cnt <= 5'd16), 128'd1);
            if (bus.wb_read) begin
                chk("raddr", 128'(bus.wb_raddr), 128'(exp_addr));
                exp_addr = exp_addr + 13'd1;
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_mvalid", 128'(bus.mvalid), 128'd1);
                chk("hold_rdata", bus.rdata, prev_rdata);
            end
            if (bus.mvalid && bus.mready) begin
                if (exp_q.size() < 4) begin
                    chk("exp_underflow", 128'(exp_q.size()), 128'd4);
                end else begin
                    exp_beat = {exp_q[3], exp_q[2], exp_q[1], exp_q[0]};
                    repeat (4) void'(exp_q.pop_front());
                    chk("beat", bus.rdata, exp_beat);
                end
                beats++;
            end
            prev_valid = bus.mvalid;
            prev_ready = bus.mready;
            prev_rdata = bus.rdata;
        end
    end

    // driver: one job; bp 0=ready high, 1=10-cycle stall after first beat,
    // 2=random ready; end_mode 0=drop, 1=drop with read in flight, 2=reset
    task automatic run_job(input logic m256, input logic [12:0] st, input int nbeats,
                           input int bp, input int end_mode);
        int w;
        int cyc;
        int t;
        bit bp_done;
        w       = m256 ? W256 : W416;
        cyc     = 0;
        t       = 0;
        bp_done = 1'b0;
        exp_q.delete();
        for (int l = 0; l < (nbeats*4)/w + 4; l++)
            for (int j = 0; j < w; j++) exp_q.push_back(word_of(st + 13'(l), j));
        exp_addr   = st;
        beats      = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        maddr_sram_start = {19'($urandom), st};
        bus.mready = 1'b1;
        mon_en     = 1'b1;
        if (m256) mode_wb2m256 = 1'b1;
        else      mode_wb2m416 = 1'b1;
        @(posedge xclk); #1;
        chk("start_rd", 128'(bus.wb_read), 128'd1);
        chk("start_raddr", 128'(bus.wb_raddr), 128'(st));
        chk("start_mode", 128'(dbg_mode), 128'(m256 ? MODE_256 : MODE_416));
        @(posedge xclk); #1;
        chk("lat_mvalid_lo", 128'(bus.mvalid), 128'd0);
        @(posedge xclk); #1;
        chk("lat_mvalid_hi", 128'(bus.mvalid), 128'd1);
        while (beats < nbeats && cyc < 3000) begin
            if (bp == 2) begin
                bus.mready = ($urandom_range(0, 3) != 0);
            end else if (bp == 1 && beats >= 1 && !bp_done) begin
                bus.mready = 1'b0;
                bp_done    = 1'b1;
                repeat (10) begin
                    @(posedge xclk); #1;
                    chk("bp_mvalid", 128'(bus.mvalid), 128'd1);
                    cyc++;
                end
                bus.mready = 1'b1;
            end
            @(posedge xclk); #1;
            cyc++;
        end
        chk("beats_done", 128'(beats), 128'(nbeats));
        if (end_mode == 2) begin
            mon_en   = 1'b0;
            xreset_n = 1'b0;
            #1;
            chk("arst_wb_read", 128'(bus.wb_read), 128'd0);
            chk("arst_raddr", 128'(bus.wb_raddr), 128'd0);
            chk("arst_mvalid", 128'(bus.mvalid), 128'd0);
            chk("arst_rdata", bus.rdata, 128'd0);
            chk("arst_cnt", 128'(dbg_cnt), 128'd0);
            mode_wb2m416 = 1'b0;
            mode_wb2m256 = 1'b0;
            @(posedge xclk); #1;
            xreset_n = 1'b1;
            @(posedge xclk); #1;
            chk("post_rst_mvalid", 128'(bus.mvalid), 128'd0);
            chk("post_rst_rd", 128'(bus.wb_read), 128'd0);
        end else begin
            if (end_mode == 1) begin
                bus.mready = 1'b1;
                while (!bus.wb_read && t < 40) begin
                    @(posedge xclk); #1;
                    t++;
                end
                chk("inflight_seen", 128'(bus.wb_read), 128'd1);
            end
            mon_en       = 1'b0;
            mode_wb2m416 = 1'b0;
            mode_wb2m256 = 1'b0;
            @(posedge xclk); #1;
            chk("drop_mvalid", 128'(bus.mvalid), 128'd0);
            chk("drop_rd", 128'(bus.wb_read), 128'd0);
            chk("drop_cnt", 128'(dbg_cnt), 128'd0);
            maddr_sram_start = 32'($urandom);
            @(posedge xclk); #1;
            chk("idle_raddr", 128'(bus.wb_raddr), 128'(maddr_sram_start[12:0]));
        end
        exp_q.delete();
    endtask

    initial begin
        xreset_n         = 1'b0;
        mode_wb2m416     = 1'b0;
        mode_wb2m256     = 1'b0;
        maddr_sram_start = 32'h0;
        bus.mready       = 1'b0;
        repeat (3) @(posedge xclk);
        #1;
        chk("rst_wb_read", 128'(bus.wb_read), 128'd0);
        chk("rst_raddr", 128'(bus.wb_raddr), 128'd0);
        chk("rst_mvalid", 128'(bus.mvalid), 128'd0);
        chk("rst_rdata", bus.rdata, 128'd0);
        chk("rst_cnt", 128'(dbg_cnt), 128'd0);
        xreset_n = 1'b1;
        @(posedge xclk); #1;

        run_job(1'b0, 13'h0100, 13, 0, 0);
        run_job(1'b1, 13'h0000, 12, 0, 0);
        run_job(1'b0, 13'h0040, 16, 1, 0);
        run_job(1'b1, 13'h0080, 16, 1, 0);
        run_job(1'b0, 13'h0100, 6, 0, 1);
        run_job(1'b0, 13'h0200, 13, 0, 0);
        run_job(1'b0, 13'h1FFF, 8, 0, 0);
        run_job(1'b1, 13'($urandom_range(0, 8191)), 24, 2, 1);
        run_job(1'b0, 13'($urandom_range(0, 8191)), 30, 2, 0);
        run_job(1'b0, 13'h0100, 5, 0, 2);
        run_job(1'b0, 13'h0100, 13, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
        $fatal(1);
    end
endmodule
